// File: rtl/conv_mac_unit.sv
// conv_mac_unit: sequential multiply-accumulate for one convolution / FC window.
// Accepts KERNEL_SIZE signed (pixel, weight) pairs after a start/bias load,
// accumulates the products in the 2*FRAC_BITS fixed-point domain, then
// rescales, optionally applies ReLU, saturates and emits one result pulse.
module conv_mac_unit #(
  parameter int IN_WIDTH    = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 25,
  parameter int FRAC_BITS   = 8,
  parameter int ACC_WIDTH   = 48,
  parameter int RELU_EN     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [IN_WIDTH-1:0]   bias,
  input  logic signed [IN_WIDTH-1:0]   pixel_in,
  input  logic signed [IN_WIDTH-1:0]   weight_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] result_out,
  output logic                         result_valid,
  output logic                         overflow,
  output logic                         busy
);

  localparam int CNT_W  = $clog2(KERNEL_SIZE + 1);
  localparam int PROD_W = 2 * IN_WIDTH;

  // Saturation bounds of the output format, expressed at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t                         state_q, state_d;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic signed [PROD_W-1:0]       prod_q, prod_d;
  logic                           prod_vld_q, prod_vld_d;
  logic signed [DATA_WIDTH-1:0]   result_q, result_d;
  logic                           result_valid_q, result_valid_d;
  logic                           overflow_q, overflow_d;
  logic                           accept;
  logic [DATA_WIDTH:0]            sat_res;
  logic signed [ACC_WIDTH-1:0]    bias_ext;
  logic signed [ACC_WIDTH-1:0]    prod_ext;

  // Drop the product fraction (floor), apply ReLU, then clamp to DATA_WIDTH.
  // Returns {overflow, value}.
  function automatic logic [DATA_WIDTH:0] rescale_sat(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] s;
    s = a >>> FRAC_BITS;
    if (RELU_EN != 0 && s < 0) return '0;
    if (s > SAT_MAX) return {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
    if (s < SAT_MIN) return {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
    return {1'b0, s[DATA_WIDTH-1:0]};
  endfunction

  assign bias_ext = {{(ACC_WIDTH-IN_WIDTH){bias[IN_WIDTH-1]}}, bias};
  assign prod_ext = {{(ACC_WIDTH-PROD_W){prod_q[PROD_W-1]}}, prod_q};

  // Next-state, datapath update and handshake decode.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    prod_d         = prod_q;
    prod_vld_d     = 1'b0;
    result_d       = result_q;
    result_valid_d = 1'b0;
    overflow_d     = 1'b0;
    in_ready       = (state_q == ACCUM);
    accept         = in_ready && in_valid;
    sat_res        = rescale_sat(acc_q);

    // The product registered on the previous accept is folded in one edge later,
    // so the multiplier and adder sit in separate stages.
    if (prod_vld_q) acc_d = acc_q + prod_ext;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Bias is shifted into the 2*FRAC_BITS product format.
          acc_d   = bias_ext <<< FRAC_BITS;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          prod_d     = pixel_in * weight_in;
          prod_vld_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(KERNEL_SIZE - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
        result_d       = sat_res[DATA_WIDTH-1:0];
        overflow_d     = sat_res[DATA_WIDTH];
        result_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      cnt_q          <= '0;
      prod_q         <= '0;
      prod_vld_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      prod_q         <= prod_d;
      prod_vld_q     <= prod_vld_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign result_out   = result_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != IDLE);

endmodule
